// File: rtl/reg_writeback_unit_pkg.sv
// Shared definitions for the writeback stage: load-type codes, the zero register and the WB slot layout.
package reg_writeback_unit_pkg;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LH  = 3'd1;
  localparam logic [2:0] LT_LHU = 3'd2;
  localparam logic [2:0] LT_LB  = 3'd3;
  localparam logic [2:0] LT_LBU = 3'd4;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        regwrite;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_slot_t;

endpackage

// File: rtl/reg_writeback_unit_pending_fifo.sv
// Pending queue for late multi-cycle results: FIFO order, per-entry live bit, kill-by-address,
// and a destination mask covering every live entry.
module wb_pending_fifo
  import reg_writeback_unit_pkg::*;
#(
  parameter int LONG_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [4:0]  push_addr,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        kill,
  input  logic [4:0]  kill_addr,
  output logic        ready,
  output logic        head_valid,
  output logic        head_live,
  output logic [4:0]  head_addr,
  output logic [31:0] head_data,
  output logic [31:0] pending_mask
);

  localparam int PW = (LONG_DEPTH > 1) ? $clog2(LONG_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [LONG_DEPTH-1:0] live_q;
  logic [4:0]            addr_q [LONG_DEPTH];
  logic [31:0]           data_q [LONG_DEPTH];
  logic                  accept;

  assign ready      = count < CW'(LONG_DEPTH);
  assign head_valid = count != '0;
  assign accept     = push && ready;
  assign head_live  = head_valid && live_q[head];
  assign head_addr  = addr_q[head];
  assign head_data  = data_q[head];

  // Live bits are cleared on pop, so a set bit always marks an occupied slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      for (int i = 0; i < LONG_DEPTH; i++) begin
        if (kill && addr_q[i] == kill_addr) live_q[i] <= 1'b0;
      end
      if (pop && head_valid) begin
        live_q[head] <= 1'b0;
        head         <= head + 1'b1;
      end
      if (accept) begin
        live_q[tail] <= !(kill && push_addr == kill_addr);
        tail         <= tail + 1'b1;
      end
      count <= count + CW'(accept) - CW'(pop && head_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < LONG_DEPTH; i++) begin
      if (live_q[i]) pending_mask[addr_q[i]] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Writeback stage: MEM/WB register with load alignment, merged with late results from the pending
// queue onto the single register-file write port.
module reg_writeback_unit
  import reg_writeback_unit_pkg::*;
#(
  parameter int LONG_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemValid,
  input  logic        MemRegWrite,
  input  logic        MemToReg,
  input  logic [4:0]  MemWriteAddr,
  input  logic [31:0] MemAluResult,
  input  logic [31:0] MemReadData,
  input  logic [2:0]  MemLoadType,
  input  logic        LongValid,
  input  logic [4:0]  LongAddr,
  input  logic [31:0] LongData,
  output logic        LongReady,
  output logic [31:0] WriteData,
  output logic [4:0]  WriteAddr,
  output logic        RegWrite,
  output logic [31:0] PendingMask
);

  // Big-endian lanes: offset 0 is the most significant byte; halves use offset bit 1 only.
  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] off,
                                             input logic [2:0] lt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (lt)
      LT_LH:   r = {{16{h[15]}}, h};
      LT_LHU:  r = {16'h0000, h};
      LT_LB:   r = {{24{b[7]}}, b};
      LT_LBU:  r = {24'h000000, b};
      default: r = word;
    endcase
    return r;
  endfunction

  logic        vld_p1;
  wb_slot_t    wb_p1;
  logic        wb_write;
  logic        fifo_ready;
  logic        head_valid;
  logic        head_live;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        use_queue;
  logic        push;
  logic        pop;

  // ---- MEM -> WB boundary ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      wb_p1  <= '0;
    end else begin
      vld_p1         <= MemValid;
      wb_p1.regwrite <= MemRegWrite;
      wb_p1.addr     <= MemWriteAddr;
      wb_p1.data     <= MemToReg ? load_align(MemReadData, MemAluResult[1:0], MemLoadType)
                                 : MemAluResult;
    end
  end

  assign wb_write  = vld_p1 && wb_p1.regwrite && wb_p1.addr != REG_ZERO;
  assign use_queue = !wb_write && head_live;
  // A killed head is retired immediately; a live head waits for a free write port.
  assign pop       = head_valid && (!head_live || !wb_write);
  assign LongReady = rst_n && fifo_ready;
  assign push      = LongValid && LongReady && LongAddr != REG_ZERO;

  wb_pending_fifo #(
    .LONG_DEPTH(LONG_DEPTH)
  ) u_pending (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_addr   (LongAddr),
    .push_data   (LongData),
    .pop         (pop),
    .kill        (wb_write),
    .kill_addr   (wb_p1.addr),
    .ready       (fifo_ready),
    .head_valid  (head_valid),
    .head_live   (head_live),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .pending_mask(PendingMask)
  );

  assign RegWrite  = wb_write || use_queue;
  assign WriteAddr = use_queue ? head_addr : wb_p1.addr;
  assign WriteData = use_queue ? head_data : wb_p1.data;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Bench for reg_writeback_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_reg_writeback_unit;
  import reg_writeback_unit_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemValid, MemRegWrite, MemToReg;
  logic [4:0]  MemWriteAddr;
  logic [31:0] MemAluResult, MemReadData;
  logic [2:0]  MemLoadType;
  logic        LongValid;
  logic [4:0]  LongAddr;
  logic [31:0] LongData;
  logic        LongReady;
  logic [31:0] WriteData;
  logic [4:0]  WriteAddr;
  logic        RegWrite;
  logic [31:0] PendingMask;

  always #5 clk = ~clk;

  reg_writeback_unit #(.LONG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemValid(MemValid), .MemRegWrite(MemRegWrite), .MemToReg(MemToReg),
    .MemWriteAddr(MemWriteAddr), .MemAluResult(MemAluResult), .MemReadData(MemReadData),
    .MemLoadType(MemLoadType),
    .LongValid(LongValid), .LongAddr(LongAddr), .LongData(LongData), .LongReady(LongReady),
    .WriteData(WriteData), .WriteAddr(WriteAddr), .RegWrite(RegWrite), .PendingMask(PendingMask)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the WB slot as plain fields, the pending queue as an ordered list.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  bit          m_vld, m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] lt);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (24 - 8 * int'(off)));
    h = 16'(w >> (off[1] ? 0 : 16));
    case (lt)
      LT_LB:   return 32'($signed(b));
      LT_LBU:  return 32'(b);
      LT_LH:   return 32'($signed(h));
      LT_LHU:  return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic bit m_wb_write();
    return m_vld && m_we && m_addr != 5'd0;
  endfunction

  function automatic bit exp_we();
    return m_wb_write() || (q.size() > 0 && q[0].live);
  endfunction

  function automatic logic [4:0] exp_addr();
    return m_wb_write() ? m_addr : q[0].addr;
  endfunction

  function automatic logic [31:0] exp_data();
    return m_wb_write() ? m_data : q[0].data;
  endfunction

  function automatic logic [31:0] exp_mask();
    logic [31:0] m;
    m = '0;
    foreach (q[i]) if (q[i].live) m[q[i].addr] = 1'b1;
    return m;
  endfunction

  function automatic bit exp_ready();
    return rst_n && q.size() < DEPTH;
  endfunction

  task automatic model_update();
    bit         ww;
    bit         do_pop;
    logic [4:0] ka;
    if (!rst_n) begin
      q.delete();
      m_vld = 0; m_we = 0; m_addr = '0; m_data = '0;
    end else begin
      ww = m_wb_write();
      ka = m_addr;
      do_pop = q.size() > 0 && (!q[0].live || !ww);
      if (ww) foreach (q[i]) if (q[i].addr == ka) q[i].live = 0;
      if (do_pop) void'(q.pop_front());
      if (LongValid && q.size() < DEPTH + (do_pop ? 1 : 0) && LongAddr != 5'd0 &&
          (q.size() - (do_pop ? 0 : 0)) >= 0) begin
      end
    end
  endtask

  // Acceptance is judged on the pre-edge occupancy, so it is computed before the model moves.
  task automatic tick();
    bit accept;
    bit ww;
    logic [4:0] ka;
    @(posedge clk);
    accept = rst_n && LongValid && q.size() < DEPTH;
    ww = m_wb_write();
    ka = m_addr;
    model_update();
    if (rst_n) begin
      if (accept && LongAddr != 5'd0)
        q.push_back('{addr: LongAddr, data: LongData, live: !(ww && LongAddr == ka)});
      m_vld  = MemValid;
      m_we   = MemRegWrite;
      m_addr = MemWriteAddr;
      m_data = MemToReg ? ref_load(MemReadData, MemAluResult[1:0], MemLoadType) : MemAluResult;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic mem_in(input bit v, input bit we, input bit toreg, input logic [4:0] a,
                        input logic [31:0] alu, input logic [31:0] rd, input logic [2:0] lt);
    MemValid = v; MemRegWrite = we; MemToReg = toreg; MemWriteAddr = a;
    MemAluResult = alu; MemReadData = rd; MemLoadType = lt;
  endtask

  task automatic long_in(input bit v, input logic [4:0] a, input logic [31:0] d);
    LongValid = v; LongAddr = a; LongData = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_in(1, 1, 0, 5'd9, 32'h1234, 32'h0, LT_LW);
    long_in(1, 5'd4, 32'h44);
    #1;
    vectors++;
    if (LongReady !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_low: got %0b want 0", LongReady);
    end
    tick();
    tick();
    vectors++;
    if ({RegWrite, WriteAddr, WriteData, PendingMask, LongReady} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got we=%0b addr=%0d data=%h mask=%h rdy=%0b want all zero",
               RegWrite, WriteAddr, WriteData, PendingMask, LongReady);
    end
    rst_n = 1'b1;
    mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
    long_in(0, 5'd0, 32'h0);
    #1;
    vectors++;
    if ({RegWrite, PendingMask, LongReady} !== {1'b0, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_release: got we=%0b mask=%h rdy=%0b want 0/0/1", RegWrite, PendingMask, LongReady);
    end
  endtask

  logic        ld_toreg [9] = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
  logic [31:0] ld_alu   [9] = '{32'h0, 32'h1, 32'h1, 32'h2, 32'h0, 32'h3, 32'h13579BDF, 32'h3, 32'h1};
  logic [31:0] ld_rd    [9] = '{32'hDEADBEEF, 32'h12F45678, 32'h12F45678, 32'h1234F678, 32'h1234F678,
                                32'h12F45678, 32'hFFFFFFFF, 32'h80007FFF, 32'h80007FFF};
  logic [2:0]  ld_lt    [9] = '{LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU, LT_LB, LT_LB, LT_LH, LT_LH};
  logic [31:0] ld_exp   [9] = '{32'hDEADBEEF, 32'hFFFFFFF4, 32'h000000F4, 32'hFFFFF678, 32'h00001234,
                                32'h00000078, 32'h13579BDF, 32'h00007FFF, 32'hFFFF8000};

  task automatic test_load_align();
    for (int i = 0; i < 9; i++) begin
      mem_in(1, 1, ld_toreg[i], 5'(i + 5), ld_alu[i], ld_rd[i], ld_lt[i]);
      tick();
      vectors++;
      if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'(i + 5), ld_exp[i]}) begin
        miscompares++;
        $display("FAIL load_align[%0d]: got we=%0b addr=%0d data=%h want 1/%0d/%h",
                 i, RegWrite, WriteAddr, WriteData, i + 5, ld_exp[i]);
      end
    end
    mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
    tick();
  endtask

  task automatic test_hold_drain();
    mem_in(1, 1, 0, 5'd3, 32'h33, 32'h0, LT_LW);
    long_in(1, 5'd7, 32'hAA);
    tick();
    long_in(0, 5'd0, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
      vectors++;
      if ({RegWrite, WriteAddr, WriteData, PendingMask} !== {1'b1, 5'd3, 32'h33, 32'h80}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got we=%0b addr=%0d data=%h mask=%h want 1/3/33/80",
                 k, RegWrite, WriteAddr, WriteData, PendingMask);
      end
      tick();
    end
    vectors++;
    if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd7, 32'hAA}) begin
      miscompares++;
      $display("FAIL drain_write: got we=%0b addr=%0d data=%h want 1/7/aa", RegWrite, WriteAddr, WriteData);
    end
    tick();
    vectors++;
    if ({RegWrite, PendingMask} !== {1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL drain_after: got we=%0b mask=%h want 0/0", RegWrite, PendingMask);
    end
  endtask

  task automatic test_backpressure();
    mem_in(1, 1, 0, 5'd1, 32'h1, 32'h0, LT_LW);
    long_in(1, 5'd10, 32'h100);
    tick();
    long_in(1, 5'd11, 32'h101);
    vectors++;
    if (LongReady !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_one_entry_ready: got %0b want 1", LongReady);
    end
    tick();
    mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
    long_in(1, 5'd12, 32'h102);
    vectors++;
    if ({LongReady, PendingMask} !== {1'b0, 32'h00000C00}) begin
      miscompares++;
      $display("FAIL bp_full: got rdy=%0b mask=%h want 0/00000c00", LongReady, PendingMask);
    end
    tick();
    vectors++;
    if ({LongReady, RegWrite, WriteAddr, WriteData} !== {1'b0, 1'b1, 5'd10, 32'h100}) begin
      miscompares++;
      $display("FAIL bp_drain1: got rdy=%0b we=%0b addr=%0d data=%h want 0/1/10/100",
               LongReady, RegWrite, WriteAddr, WriteData);
    end
    tick();
    vectors++;
    if ({LongReady, RegWrite, WriteAddr, WriteData} !== {1'b1, 1'b1, 5'd11, 32'h101}) begin
      miscompares++;
      $display("FAIL bp_reopen: got rdy=%0b we=%0b addr=%0d data=%h want 1/1/11/101",
               LongReady, RegWrite, WriteAddr, WriteData);
    end
    tick();
    long_in(0, 5'd0, 32'h0);
    vectors++;
    if ({RegWrite, WriteAddr, WriteData, PendingMask} !== {1'b1, 5'd12, 32'h102, 32'h00001000}) begin
      miscompares++;
      $display("FAIL bp_third: got we=%0b addr=%0d data=%h mask=%h want 1/12/102/00001000",
               RegWrite, WriteAddr, WriteData, PendingMask);
    end
    tick();
    vectors++;
    if ({RegWrite, PendingMask, LongReady} !== {1'b0, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL bp_empty: got we=%0b mask=%h rdy=%0b want 0/0/1", RegWrite, PendingMask, LongReady);
    end
  endtask

  task automatic test_kill();
    mem_in(1, 1, 0, 5'd2, 32'h2, 32'h0, LT_LW);
    long_in(1, 5'd9, 32'h11);
    tick();
    long_in(0, 5'd0, 32'h0);
    mem_in(1, 1, 0, 5'd9, 32'h22, 32'h0, LT_LW);
    vectors++;
    if ({RegWrite, WriteAddr, PendingMask} !== {1'b1, 5'd2, 32'h00000200}) begin
      miscompares++;
      $display("FAIL kill_queued: got we=%0b addr=%0d mask=%h want 1/2/00000200", RegWrite, WriteAddr, PendingMask);
    end
    tick();
    mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
    vectors++;
    if ({RegWrite, WriteAddr, WriteData} !== {1'b1, 5'd9, 32'h22}) begin
      miscompares++;
      $display("FAIL kill_pipe_write: got we=%0b addr=%0d data=%h want 1/9/22", RegWrite, WriteAddr, WriteData);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({RegWrite, PendingMask} !== {1'b0, 32'd0}) begin
        miscompares++;
        $display("FAIL kill_no_late_write[%0d]: got we=%0b addr=%0d mask=%h want we=0 mask=0",
                 k, RegWrite, WriteAddr, PendingMask);
      end
      tick();
    end
  endtask

  task automatic test_zero_and_reset();
    mem_in(1, 1, 0, 5'd0, 32'h55, 32'h0, LT_LW);
    tick();
    vectors++;
    if (RegWrite !== 1'b0) begin
      miscompares++;
      $display("FAIL dest0_pipe: got we=%0b want 0", RegWrite);
    end
    mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
    long_in(1, 5'd0, 32'hBAD);
    tick();
    long_in(0, 5'd0, 32'h0);
    vectors++;
    if ({RegWrite, PendingMask, LongReady} !== {1'b0, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL dest0_long: got we=%0b mask=%h rdy=%0b want 0/0/1", RegWrite, PendingMask, LongReady);
    end
    mem_in(1, 1, 0, 5'd4, 32'h4, 32'h0, LT_LW);
    long_in(1, 5'd20, 32'h20);
    tick();
    long_in(1, 5'd21, 32'h21);
    tick();
    long_in(0, 5'd0, 32'h0);
    vectors++;
    if ({PendingMask, LongReady} !== {32'h00300000, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_prefill: got mask=%h rdy=%0b want 00300000/0", PendingMask, LongReady);
    end
    rst_n = 1'b0;
    mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
    tick();
    vectors++;
    if ({RegWrite, WriteAddr, WriteData, PendingMask, LongReady} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_midop: got we=%0b addr=%0d data=%h mask=%h rdy=%0b want all zero",
               RegWrite, WriteAddr, WriteData, PendingMask, LongReady);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({RegWrite, PendingMask, LongReady} !== {1'b0, 32'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL rst_queue_empty[%0d]: got we=%0b mask=%h rdy=%0b want 0/0/1",
                 k, RegWrite, PendingMask, LongReady);
      end
    end
  endtask

  task automatic test_random();
    bit ew;
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      mem_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom, $urandom, 3'($urandom_range(0, 4)));
      long_in(1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
      #1;
      ew = exp_we();
      vectors++;
      if (RegWrite !== ew || (ew && (WriteAddr !== exp_addr() || WriteData !== exp_data())) ||
          PendingMask !== exp_mask() || LongReady !== exp_ready()) begin
        miscompares++;
        $display("FAIL random[%0d]: got we=%0b addr=%0d data=%h mask=%h rdy=%0b want we=%0b addr=%0d data=%h mask=%h rdy=%0b",
                 n, RegWrite, WriteAddr, WriteData, PendingMask, LongReady,
                 ew, ew ? exp_addr() : 5'd0, ew ? exp_data() : 32'd0, exp_mask(), exp_ready());
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    mem_in(0, 0, 0, 5'd0, 32'h0, 32'h0, LT_LW);
    long_in(0, 5'd0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    test_reset();
    test_load_align();
    test_hold_drain();
    test_backpressure();
    test_kill();
    test_zero_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
